// File: rtl/shifter_pkg.sv
// ---------------------------------------------------------------------------
// shifter_pkg
// Shared definitions for the 8-bit barrel shifter and the command queue that
// feeds it.
//   SH_DATA_W   : operand width
//   SH_AMT_W    : shift amount width
//   DIR_LEFT    : dir encoding for a left shift
//   DIR_RIGHT   : dir encoding for a right shift
//   shift_cmd_t : one queued command {data, amt, dir}, 12 bits packed
// ---------------------------------------------------------------------------
package shifter_pkg;

    localparam int SH_DATA_W = 8;
    localparam int SH_AMT_W  = 3;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef struct packed {
        logic [SH_DATA_W-1:0] data;
        logic [SH_AMT_W-1:0]  amt;
        logic                 dir;
    } shift_cmd_t;

endpackage

// File: rtl/shift_cmd_fifo.sv
// ---------------------------------------------------------------------------
// shift_cmd_fifo
// Synchronous DEPTH-entry storage for shift commands with read/write pointers
// and an occupancy count. Read data is the current head entry, visible
// combinationally from the storage array.
//   Clock   : rising-edge clock
//   Reset   : asynchronous active-high reset (pointers and count only)
//   wr_en   : write wr_cmd at the tail (ignored when full)
//   wr_cmd  : command to enqueue
//   rd_en   : drop the head entry (ignored when empty)
//   rd_cmd  : current head entry
//   count   : current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module shift_cmd_fifo
    import shifter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         wr_en,
    input  shift_cmd_t                   wr_cmd,
    input  logic                         rd_en,
    output shift_cmd_t                   rd_cmd,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    shift_cmd_t        mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              wr_ok;
    logic              rd_ok;

    // Gate both sides locally so the count can never over- or underflow,
    // whatever the caller drives.
    assign wr_ok  = wr_en && (count != CNT_W'(DEPTH));
    assign rd_ok  = rd_en && (count != '0);
    assign rd_cmd = mem[rd_ptr];

    // Storage array: no reset, stale contents are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge Clock) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_cmd;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; the count
    // moves only when exactly one of push/pop happens.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/shift_cmd_queue.sv
// ---------------------------------------------------------------------------
// shift_cmd_queue
// Buffers shift commands from a producer and issues at most one per cycle
// onto the barrel shifter inputs. res_valid marks the cycle in which the
// shifter's registered data_out holds an issued command's result.
//   Clock, Reset                       : clock, async active-high reset
//   push_valid/push_ready              : producer handshake
//   push_data/push_amt/push_dir        : command fields
//   issue_en                           : downstream permits issue this cycle
//   sh_data_in/sh_shift_amt/sh_dir     : registered shifter inputs
//   issue_valid                        : sh_* carry a new command this cycle
//   res_valid                          : shifter data_out holds a result
//   count                              : queue occupancy
// ---------------------------------------------------------------------------
module shift_cmd_queue
    import shifter_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int SHIFT_LAT = 1
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         push_valid,
    output logic                         push_ready,
    input  logic [SH_DATA_W-1:0]         push_data,
    input  logic [SH_AMT_W-1:0]          push_amt,
    input  logic                         push_dir,
    input  logic                         issue_en,
    output logic [SH_DATA_W-1:0]         sh_data_in,
    output logic [SH_AMT_W-1:0]          sh_shift_amt,
    output logic                         sh_dir,
    output logic                         issue_valid,
    output logic                         res_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CNT_W = $clog2(DEPTH+1);

    shift_cmd_t            push_cmd;
    shift_cmd_t            head_cmd;
    logic                  push_fire;
    logic                  pop_fire;
    logic [SHIFT_LAT-1:0]  res_pipe;

    // Ready depends on the registered count only, so a full queue refuses a
    // push even when a pop happens in the same cycle.
    assign push_ready = (count < CNT_W'(DEPTH));
    assign push_fire  = push_valid && push_ready;
    assign pop_fire   = issue_en && (count != '0);
    assign push_cmd   = '{data: push_data, amt: push_amt, dir: push_dir};
    assign res_valid  = res_pipe[SHIFT_LAT-1];

    shift_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clock  (Clock),
        .Reset  (Reset),
        .wr_en  (push_fire),
        .wr_cmd (push_cmd),
        .rd_en  (pop_fire),
        .rd_cmd (head_cmd),
        .count  (count)
    );

    // Issue registers: load the head entry on a pop, otherwise keep the
    // last issued command on the shifter inputs.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sh_data_in   <= '0;
            sh_shift_amt <= '0;
            sh_dir       <= 1'b0;
            issue_valid  <= 1'b0;
        end else begin
            issue_valid <= pop_fire;
            if (pop_fire) begin
                sh_data_in   <= head_cmd.data;
                sh_shift_amt <= head_cmd.amt;
                sh_dir       <= head_cmd.dir;
            end
        end
    end

    // Delay line that tracks commands through the shifter's register stages;
    // clearing it on reset drops every in-flight result.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            res_pipe <= '0;
        end else begin
            res_pipe[0] <= issue_valid;
            for (int i = 1; i < SHIFT_LAT; i++) begin
                res_pipe[i] <= res_pipe[i-1];
            end
        end
    end

endmodule

// File: tb/tb_shift_cmd_queue.sv
// ---------------------------------------------------------------------------
// tb_shift_cmd_queue
// Directed bench for shift_cmd_queue with a queue-based reference model and a
// bench-side registered shifter so the result data can be checked too.
// ---------------------------------------------------------------------------
module tb_shift_cmd_queue;
    import shifter_pkg::*;

    localparam int DEPTH     = 4;
    localparam int SHIFT_LAT = 1;
    localparam int CNT_W     = $clog2(DEPTH+1);

    logic              Clock = 1'b0;
    logic              Reset;
    logic              push_valid;
    logic              push_ready;
    logic [7:0]        push_data;
    logic [2:0]        push_amt;
    logic              push_dir;
    logic              issue_en;
    logic [7:0]        sh_data_in;
    logic [2:0]        sh_shift_amt;
    logic              sh_dir;
    logic              issue_valid;
    logic              res_valid;
    logic [CNT_W-1:0]  count;

    int total = 0;
    int bad   = 0;

    always #5 Clock = ~Clock;

    shift_cmd_queue #(
        .DEPTH     (DEPTH),
        .SHIFT_LAT (SHIFT_LAT)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .push_valid   (push_valid),
        .push_ready   (push_ready),
        .push_data    (push_data),
        .push_amt     (push_amt),
        .push_dir     (push_dir),
        .issue_en     (issue_en),
        .sh_data_in   (sh_data_in),
        .sh_shift_amt (sh_shift_amt),
        .sh_dir       (sh_dir),
        .issue_valid  (issue_valid),
        .res_valid    (res_valid),
        .count        (count)
    );

    // Stand-in for the downstream barrel shifter: one register stage.
    logic [7:0] sh_out;
    always @(posedge Clock) begin
        sh_out <= sh_dir ? (sh_data_in >> sh_shift_amt) : (sh_data_in << sh_shift_amt);
    end

    // Reference model: a plain queue of commands, the last issued command,
    // and the set of cycles in which an issue happened.
    shift_cmd_t mdl_q[$];
    shift_cmd_t mdl_sh = '0;
    bit         mdl_iv = 1'b0;
    bit         mdl_issued[int];
    int         mdl_cyc = 0;
    bit         check_en = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mdl_q.delete();
        mdl_sh = '0;
        mdl_iv = 1'b0;
        mdl_issued.delete();
    endtask

    // One clock edge worth of behaviour, evaluated with the inputs that were
    // presented before the edge.
    task automatic modelStep();
        bit push_ok;
        bit pop_ok;
        push_ok = push_valid && (mdl_q.size() < DEPTH);
        pop_ok  = issue_en && (mdl_q.size() > 0);
        mdl_cyc++;
        mdl_iv = 1'b0;
        if (pop_ok) begin
            mdl_sh = mdl_q.pop_front();
            mdl_iv = 1'b1;
            mdl_issued[mdl_cyc] = 1'b1;
        end
        if (push_ok) begin
            mdl_q.push_back('{data: push_data, amt: push_amt, dir: push_dir});
        end
    endtask

    // Every-cycle comparison of all DUT outputs against the model.
    always @(negedge Clock) begin
        if (check_en) begin
            checkOutput("count", 32'(count), 32'(mdl_q.size()));
            checkOutput("push_ready", 32'(push_ready), 32'(mdl_q.size() < DEPTH));
            checkOutput("issue_valid", 32'(issue_valid), 32'(mdl_iv));
            checkOutput("res_valid", 32'(res_valid), 32'(mdl_issued.exists(mdl_cyc - SHIFT_LAT)));
            checkOutput("sh_data_in", 32'(sh_data_in), 32'(mdl_sh.data));
            checkOutput("sh_shift_amt", 32'(sh_shift_amt), 32'(mdl_sh.amt));
            checkOutput("sh_dir", 32'(sh_dir), 32'(mdl_sh.dir));
        end
    end

    task automatic applyStimulus(input logic pv, input logic [7:0] d, input logic [2:0] a,
                                 input logic dr, input logic ie);
        push_valid = pv;
        push_data  = d;
        push_amt   = a;
        push_dir   = dr;
        issue_en   = ie;
        @(posedge Clock);
        #1;
        if (!Reset) modelStep();
    endtask

    logic [7:0] bb_data [4] = '{8'hAA, 8'hF0, 8'h0F, 8'h01};
    logic [2:0] bb_amt  [4] = '{3'd2, 3'd3, 3'd1, 3'd7};
    logic       bb_dir  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0] bb_res  [4] = '{8'h2A, 8'h80, 8'h07, 8'h80};
    logic [7:0] fill_d  [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    initial begin
        Reset      = 1'b1;
        push_valid = 1'b0;
        push_data  = '0;
        push_amt   = '0;
        push_dir   = 1'b0;
        issue_en   = 1'b0;
        #1;
        checkOutput("rst_count", 32'(count), 0);
        checkOutput("rst_push_ready", 32'(push_ready), 1);
        checkOutput("rst_issue_valid", 32'(issue_valid), 0);
        checkOutput("rst_res_valid", 32'(res_valid), 0);
        checkOutput("rst_sh_data_in", 32'(sh_data_in), 0);
        check_en = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;

        // Single command: push, issue next edge, result one edge later.
        applyStimulus(1'b1, 8'hAA, 3'd1, 1'b0, 1'b1);
        checkOutput("t1_count", 32'(count), 1);
        checkOutput("t1_no_bypass", 32'(issue_valid), 0);
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        checkOutput("t1_issue_valid", 32'(issue_valid), 1);
        checkOutput("t1_sh_data", 32'(sh_data_in), 32'h AA);
        checkOutput("t1_sh_amt", 32'(sh_shift_amt), 1);
        checkOutput("t1_sh_dir", 32'(sh_dir), 0);
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        checkOutput("t1_res_valid", 32'(res_valid), 1);
        checkOutput("t1_data_out", 32'(sh_out), 32'h54);
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        checkOutput("t1_res_gone", 32'(res_valid), 0);

        // Back-to-back commands at full throughput.
        for (int i = 0; i < 6; i++) begin
            if (i < 4) applyStimulus(1'b1, bb_data[i], bb_amt[i], bb_dir[i], 1'b1);
            else       applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
            if (i >= 2) begin
                checkOutput("bb_res_valid", 32'(res_valid), 1);
                checkOutput("bb_data_out", 32'(sh_out), 32'(bb_res[i-2]));
            end
        end
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);

        // Fill with issue blocked, then drain in order while the fifth waits.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, fill_d[i], 3'(i), 1'(i % 2), 1'b0);
        end
        checkOutput("fill_count", 32'(count), 4);
        checkOutput("fill_ready", 32'(push_ready), 0);
        applyStimulus(1'b1, fill_d[4], 3'd4, 1'b0, 1'b0);
        checkOutput("fill_held", 32'(count), 4);
        applyStimulus(1'b1, fill_d[4], 3'd4, 1'b0, 1'b1);
        checkOutput("full_pop_count", 32'(count), 3);
        checkOutput("full_pop_issue", 32'(issue_valid), 1);
        checkOutput("full_pop_data", 32'(sh_data_in), 32'h11);
        applyStimulus(1'b1, fill_d[4], 3'd4, 1'b0, 1'b1);
        checkOutput("fifth_accept_count", 32'(count), 3);
        checkOutput("drain_data1", 32'(sh_data_in), 32'h22);
        for (int i = 2; i < 5; i++) begin
            applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
            checkOutput("drain_data", 32'(sh_data_in), 32'(fill_d[i]));
        end
        checkOutput("drain_count", 32'(count), 0);

        // Empty queue with issue enabled: nothing issues, sh_* hold.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
            checkOutput("empty_issue", 32'(issue_valid), 0);
            if (i > 0) checkOutput("empty_res", 32'(res_valid), 0);
        end
        checkOutput("empty_hold_data", 32'(sh_data_in), 32'h55);
        checkOutput("empty_count", 32'(count), 0);

        // Reset mid-stream with three queued and one in flight.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'(8'h66 + 8'(i * 17)), 3'(i + 1), 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        checkOutput("pre_rst_count", 32'(count), 3);
        checkOutput("pre_rst_issue", 32'(issue_valid), 1);
        #2;
        Reset = 1'b1;
        #1;
        modelReset();
        checkOutput("mid_rst_count", 32'(count), 0);
        checkOutput("mid_rst_issue", 32'(issue_valid), 0);
        checkOutput("mid_rst_res", 32'(res_valid), 0);
        checkOutput("mid_rst_sh_data", 32'(sh_data_in), 0);
        checkOutput("mid_rst_sh_amt", 32'(sh_shift_amt), 0);
        checkOutput("mid_rst_sh_dir", 32'(sh_dir), 0);
        checkOutput("mid_rst_ready", 32'(push_ready), 1);
        @(posedge Clock);
        #3;
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
            checkOutput("post_rst_res", 32'(res_valid), 0);
            checkOutput("post_rst_issue", 32'(issue_valid), 0);
        end
        checkOutput("post_rst_count", 32'(count), 0);

        @(negedge Clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
